// File: rtl/vidc_dma_capture.sv
// VIDC DMA capture: synchronises the raw VIDC acknowledges and data bus,
// glitch-filters the acks, emits one load strobe per accepted word and keeps
// per-frame word statistics plus sticky error flags behind a small register file.

// One acknowledge channel: two-flop synchroniser, low-run counter and
// single-shot accept / glitch detection.
module vidc_dma_ack_filter #(
    parameter int MIN_LOW = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic nack_i,
    output logic acc_o,
    output logic glitch_o
);

    localparam logic [2:0] ACC_CNT = 3'(MIN_LOW - 1);

    logic       s1_q, s2_q;
    logic [2:0] lowcnt_q, lowcnt_d;

    // Synchroniser idles high so a reset never looks like an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= nack_i;
            s2_q <= s1_q;
        end
    end

    // Count synchronised low samples, saturating so long pulses cannot wrap
    // back into the accept value.
    always_comb begin
        lowcnt_d = lowcnt_q;
        if (s2_q)
            lowcnt_d = 3'd0;
        else if (lowcnt_q != 3'd7)
            lowcnt_d = lowcnt_q + 3'd1;
    end

    // Low-run counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lowcnt_q <= 3'd0;
        else
            lowcnt_q <= lowcnt_d;
    end

    // Exactly one accept per pulse: only the sample where the run reaches
    // MIN_LOW matches.
    assign acc_o    = !s2_q && (lowcnt_q == ACC_CNT);
    // A pulse that ended before reaching MIN_LOW samples is a glitch.
    assign glitch_o = s2_q && (lowcnt_q != 3'd0) && (int'(lowcnt_q) < MIN_LOW);

endmodule

module vidc_dma_capture #(
    parameter int MIN_LOW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] vidc_d,
    input  logic        vidc_nvidak,
    input  logic        vidc_ncurak,
    input  logic        sync_flybk,
    output logic        load_dma,
    output logic        load_dma_cursor,
    output logic [31:0] load_dma_data,
    input  logic [5:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wstrobe,
    output logic [31:0] reg_rdata
);

    localparam int NUM_CH = 2;   // channel 0 = video, channel 1 = cursor

    // Sticky flag bit positions.
    localparam int F_OVL   = 0;
    localparam int F_DROP  = 1;
    localparam int F_BURST = 2;

    logic [NUM_CH-1:0] acc, glitch;

    logic [31:0] d_s1_q, d_s2_q;
    logic        flybk_s1_q, flybk_s2_q, flybk_s3_q;
    logic        flybk_rise;

    logic        load_dma_q, load_dma_cursor_q;
    logic [31:0] load_dma_data_q, load_dma_data_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic        iss_vid, iss_cur;

    logic [15:0] vid_words_q, vid_words_d;
    logic [7:0]  cur_words_q, cur_words_d;
    logic [15:0] last_vid_q, last_vid_d;
    logic [7:0]  last_cur_q, last_cur_d;
    logic [15:0] frames_q, frames_d;
    logic [7:0]  glitch_q, glitch_d;
    logic [2:0]  flags_q, flags_d;
    logic [2:0]  flag_set, flag_clr;

    logic [3:0]  reg_idx;
    logic        wr_stat, wr_glitch;
    logic        unused_bits;

    vidc_dma_ack_filter #(.MIN_LOW(MIN_LOW)) u_flt [NUM_CH-1:0] (
        .clk      (clk),
        .reset    (reset),
        .nack_i   ({vidc_ncurak, vidc_nvidak}),
        .acc_o    (acc),
        .glitch_o (glitch)
    );

    // Data bus and flyback synchronisers; data moves in lockstep with the acks
    // so d_s2 holds the word that was on the bus when the ack was sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_s1_q     <= 32'h0;
            d_s2_q     <= 32'h0;
            flybk_s1_q <= 1'b0;
            flybk_s2_q <= 1'b0;
            flybk_s3_q <= 1'b0;
        end else begin
            d_s1_q     <= vidc_d;
            d_s2_q     <= d_s1_q;
            flybk_s1_q <= sync_flybk;
            flybk_s2_q <= flybk_s1_q;
            flybk_s3_q <= flybk_s2_q;
        end
    end

    assign flybk_rise = flybk_s2_q && !flybk_s3_q;

    // Issue arbitration: video always goes first; a colliding cursor word
    // waits one cycle in the pending slot, and a second cursor word arriving
    // while the slot is busy is dropped.
    always_comb begin
        iss_vid         = acc[0];
        iss_cur         = !acc[0] && (pend_q || acc[1]);
        pend_d          = pend_q;
        pend_data_d     = pend_data_q;
        load_dma_data_d = load_dma_data_q;
        flag_set        = 3'b000;
        if (acc[0]) begin
            load_dma_data_d = d_s2_q;
            if (acc[1]) begin
                if (pend_q) begin
                    flag_set[F_DROP] = 1'b1;
                end else begin
                    pend_d          = 1'b1;
                    pend_data_d     = d_s2_q;
                    flag_set[F_OVL] = 1'b1;
                end
            end
        end else if (pend_q) begin
            load_dma_data_d = pend_data_q;
            pend_d          = 1'b0;
            if (acc[1])
                flag_set[F_DROP] = 1'b1;
        end else if (acc[1]) begin
            load_dma_data_d = d_s2_q;
        end
        if (flybk_rise && (vid_words_q[1:0] != 2'b00))
            flag_set[F_BURST] = 1'b1;
    end

    // Strobe, data and pending-slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_dma_q        <= 1'b0;
            load_dma_cursor_q <= 1'b0;
            load_dma_data_q   <= 32'h0;
            pend_q            <= 1'b0;
            pend_data_q       <= 32'h0;
        end else begin
            load_dma_q        <= iss_vid;
            load_dma_cursor_q <= iss_cur;
            load_dma_data_q   <= load_dma_data_d;
            pend_q            <= pend_d;
            pend_data_q       <= pend_data_d;
        end
    end

    assign load_dma        = load_dma_q;
    assign load_dma_cursor = load_dma_cursor_q;
    assign load_dma_data   = load_dma_data_q;

    assign reg_idx   = reg_addr[5:2];
    assign wr_stat   = reg_wstrobe && (reg_idx == 4'd0);
    assign wr_glitch = reg_wstrobe && (reg_idx == 4'd4);
    assign flag_clr  = wr_stat ? reg_wdata[2:0] : 3'b000;

    // Frame accounting, glitch count and sticky flags. On a flyback rise the
    // running counts are latched first, so a word issued in that same cycle
    // lands in the new frame.
    always_comb begin
        vid_words_d = vid_words_q;
        cur_words_d = cur_words_q;
        last_vid_d  = last_vid_q;
        last_cur_d  = last_cur_q;
        frames_d    = frames_q;
        if (flybk_rise) begin
            last_vid_d  = vid_words_q;
            last_cur_d  = cur_words_q;
            vid_words_d = 16'h0;
            cur_words_d = 8'h0;
            frames_d    = frames_q + 16'h1;
        end
        if (iss_vid && (vid_words_d != 16'hFFFF))
            vid_words_d = vid_words_d + 16'h1;
        if (iss_cur && (cur_words_d != 8'hFF))
            cur_words_d = cur_words_d + 8'h1;
        // A set in the same cycle as a write-1-to-clear keeps the flag.
        flags_d  = (flags_q & ~flag_clr) | flag_set;
        glitch_d = (wr_glitch ? 8'h0 : glitch_q)
                   + {7'h0, glitch[0]} + {7'h0, glitch[1]};
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_words_q <= 16'h0;
            cur_words_q <= 8'h0;
            last_vid_q  <= 16'h0;
            last_cur_q  <= 8'h0;
            frames_q    <= 16'h0;
            glitch_q    <= 8'h0;
            flags_q     <= 3'b000;
        end else begin
            vid_words_q <= vid_words_d;
            cur_words_q <= cur_words_d;
            last_vid_q  <= last_vid_d;
            last_cur_q  <= last_cur_d;
            frames_q    <= frames_d;
            glitch_q    <= glitch_d;
            flags_q     <= flags_d;
        end
    end

    // Combinational register read mux.
    always_comb begin
        reg_rdata = 32'h0;
        case (reg_idx)
            4'd0:    reg_rdata = {24'h0, flybk_s2_q, 4'h0, flags_q};
            4'd1:    reg_rdata = {16'h0, last_vid_q};
            4'd2:    reg_rdata = {24'h0, last_cur_q};
            4'd3:    reg_rdata = {16'h0, frames_q};
            4'd4:    reg_rdata = {24'h0, glitch_q};
            default: reg_rdata = 32'h0;
        endcase
    end

    // Address LSBs and upper write-data bits carry no meaning here.
    assign unused_bits = ^{reg_addr[1:0], reg_wdata[31:3]};

endmodule

// File: tb/tb_vidc_dma_capture.sv
// Bench for vidc_dma_capture: directed stimulus, a history-based model
// checked every cycle, and hand-computed literal expectations.
module tb_vidc_dma_capture;

    localparam int MIN_LOW = 2;
    localparam int HMAX    = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] vidc_d = 32'h0;
    logic        vidc_nvidak = 1'b1;
    logic        vidc_ncurak = 1'b1;
    logic        sync_flybk = 1'b0;
    logic        load_dma, load_dma_cursor;
    logic [31:0] load_dma_data;
    logic [5:0]  reg_addr = 6'h0;
    logic [31:0] reg_wdata = 32'h0;
    logic        reg_wstrobe = 1'b0;
    logic [31:0] reg_rdata;

    vidc_dma_capture #(.MIN_LOW(MIN_LOW)) dut (
        .clk             (clk),
        .reset           (reset),
        .vidc_d          (vidc_d),
        .vidc_nvidak     (vidc_nvidak),
        .vidc_ncurak     (vidc_ncurak),
        .sync_flybk      (sync_flybk),
        .load_dma        (load_dma),
        .load_dma_cursor (load_dma_cursor),
        .load_dma_data   (load_dma_data),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_wstrobe     (reg_wstrobe),
        .reg_rdata       (reg_rdata)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- model: raw-sample history since last reset ----------
    bit          hv[HMAX];
    bit          hc[HMAX];
    bit          hf[HMAX];
    logic [31:0] hd[HMAX];
    int          n;

    bit          m_vid, m_cur, m_pend, m_flyb;
    logic [31:0] m_data, m_pdata;
    int          m_vw, m_cw, m_lv, m_lc, m_frames, m_glitch;
    bit   [2:0]  m_flags;

    function automatic bit ack_at(input int ch, input int i);
        if (i < 0) return 1'b1;
        return (ch == 0) ? hv[i] : hc[i];
    endfunction

    function automatic bit fly_at(input int i);
        if (i < 0) return 1'b0;
        return hf[i];
    endfunction

    function automatic logic [31:0] dat_at(input int i);
        if (i < 0) return 32'h0;
        return hd[i];
    endfunction

    // Length of the run of low raw samples ending at index e.
    function automatic int zrun(input int ch, input int e);
        int l = 0;
        while (e >= 0 && ack_at(ch, e) == 1'b0 && l < 8) begin
            l++;
            e--;
        end
        return l;
    endfunction

    function automatic logic [31:0] exp_reg(input int idx);
        case (idx)
            0: return {24'h0, m_flyb, 4'h0, m_flags};
            1: return 32'(m_lv);
            2: return 32'(m_lc);
            3: return 32'(m_frames);
            4: return 32'(m_glitch);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        n = 0; m_vid = 0; m_cur = 0; m_pend = 0; m_flyb = 0;
        m_data = 0; m_pdata = 0; m_vw = 0; m_cw = 0; m_lv = 0; m_lc = 0;
        m_frames = 0; m_glitch = 0; m_flags = 0;
    endtask

    // One clock edge: the ack seen this edge was sampled raw two edges
    // earlier; it is accepted when its low run has just reached MIN_LOW.
    task automatic model_step();
        bit va, ca, rise;
        bit [2:0] set, clr;
        int gl;
        logic [31:0] w;
        if (n >= HMAX) return;
        hv[n] = vidc_nvidak; hc[n] = vidc_ncurak; hf[n] = sync_flybk; hd[n] = vidc_d;
        va = (ack_at(0, n-2) == 1'b0) && (zrun(0, n-2) == MIN_LOW);
        ca = (ack_at(1, n-2) == 1'b0) && (zrun(1, n-2) == MIN_LOW);
        gl = 0;
        for (int ch = 0; ch < 2; ch++)
            if (ack_at(ch, n-2) && zrun(ch, n-3) > 0 && zrun(ch, n-3) < MIN_LOW) gl++;
        w = dat_at(n-3);
        rise = fly_at(n-2) && !fly_at(n-3);
        set = 0;
        m_vid = 0; m_cur = 0;
        if (va) begin
            m_vid = 1; m_data = w;
            if (ca) begin
                if (m_pend) set[1] = 1;
                else begin m_pend = 1; m_pdata = w; set[0] = 1; end
            end
        end else if (m_pend) begin
            m_cur = 1; m_data = m_pdata; m_pend = 0;
            if (ca) set[1] = 1;
        end else if (ca) begin
            m_cur = 1; m_data = w;
        end
        if (rise) begin
            m_lv = m_vw; m_lc = m_cw;
            if (m_vw % 4 != 0) set[2] = 1;
            m_frames = (m_frames + 1) % 65536;
            m_vw = 0; m_cw = 0;
        end
        if (m_vid && m_vw < 65535) m_vw++;
        if (m_cur && m_cw < 255) m_cw++;
        clr = (reg_wstrobe && reg_addr[5:2] == 4'd0) ? reg_wdata[2:0] : 3'b000;
        m_flags = (m_flags & ~clr) | set;
        if (reg_wstrobe && reg_addr[5:2] == 4'd4) m_glitch = 0;
        m_glitch = (m_glitch + gl) % 256;
        m_flyb = fly_at(n-1);
        n++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // Per-cycle output comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("load_dma", load_dma, m_vid);
                chk("load_dma_cursor", load_dma_cursor, m_cur);
                chk("load_dma_data", load_dma_data, m_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic rd(input string nm, input int idx, input logic [31:0] lit);
        reg_addr = 6'(idx << 2);
        #1;
        chk({nm, "_model"}, reg_rdata, exp_reg(idx));
        chk(nm, reg_rdata, lit);
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        reg_addr = 6'(idx << 2);
        reg_wdata = data;
        reg_wstrobe = 1'b1;
        @(negedge clk);
        reg_wstrobe = 1'b0;
    endtask

    task automatic vid_pulse(input logic [31:0] data);
        vidc_d = data; vidc_nvidak = 1'b0; tick(3);
        vidc_nvidak = 1'b1; tick(3);
    endtask

    task automatic cur_pulse(input logic [31:0] data);
        vidc_d = data; vidc_ncurak = 1'b0; tick(3);
        vidc_ncurak = 1'b1; tick(3);
    endtask

    int vhits, chits, vat, cat;
    logic [31:0] vdat, cdat;

    task automatic watch(input int cycles, input int release_at, input bit both);
        vhits = 0; chits = 0; vat = -1; cat = -1; vdat = 0; cdat = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (load_dma) begin vhits++; vat = i; vdat = load_dma_data; end
            if (load_dma_cursor) begin chits++; cat = i; cdat = load_dma_data; end
            if (i == release_at) begin
                vidc_nvidak = 1'b1;
                if (both) vidc_ncurak = 1'b1;
            end
        end
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(2);
        // reset state
        chk("rst_load_dma", load_dma, 1'b0);
        chk("rst_load_dma_data", load_dma_data, 32'h0);
        rd("rst_reg0", 0, 32'h0);
        rd("rst_reg3", 3, 32'h0);

        // long video pulse: one strobe MIN_LOW+2 edges after first low sample
        vidc_d = 32'hDEADBEEF;
        vidc_nvidak = 1'b0;
        watch(10, 6, 1'b0);
        chk("vid_hits", vhits, 1);
        chk("vid_latency", vat, MIN_LOW + 2);
        chk("vid_data", vdat, 32'hDEADBEEF);
        chk("vid_no_cursor", chits, 0);

        // one-cycle glitch
        vidc_nvidak = 1'b0; tick(1);
        vidc_nvidak = 1'b1; tick(6);
        rd("glitch_reg4", 4, 32'h1);

        // collision
        vidc_d = 32'h11111111;
        vidc_nvidak = 1'b0; vidc_ncurak = 1'b0;
        watch(10, 4, 1'b1);
        chk("col_vid_at", vat, 4);
        chk("col_cur_at", cat, 5);
        chk("col_vid_data", vdat, 32'h11111111);
        chk("col_cur_data", cdat, 32'h11111111);
        rd("col_reg0", 0, 32'h1);
        wr(0, 32'h1);
        rd("col_reg0_clr", 0, 32'h0);

        // frame accounting from a clean reset
        reset = 1'b1; tick(2); reset = 1'b0; tick(2);
        for (int i = 0; i < 8; i++) vid_pulse(32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) cur_pulse(32'h200 + 32'(i));
        tick(4);
        sync_flybk = 1'b1; tick(6);
        rd("f1_reg1", 1, 32'd8);
        rd("f1_reg2", 2, 32'd3);
        rd("f1_reg3", 3, 32'd1);
        rd("f1_reg0", 0, 32'h80);
        sync_flybk = 1'b0; tick(4);
        for (int i = 0; i < 6; i++) vid_pulse(32'h300 + 32'(i));
        tick(2);
        sync_flybk = 1'b1; tick(6);
        rd("f2_reg1", 1, 32'd6);
        rd("f2_reg2", 2, 32'd0);
        rd("f2_reg3", 3, 32'd2);
        rd("f2_reg0", 0, 32'h84);

        // W1C colliding with a fresh err_burst set: set wins
        wr(0, 32'h4);
        rd("w1c_reg0", 0, 32'h80);
        sync_flybk = 1'b0; tick(4);
        for (int i = 0; i < 2; i++) vid_pulse(32'h400 + 32'(i));
        tick(2);
        sync_flybk = 1'b1;
        tick(2);
        wr(0, 32'h4);
        tick(2);
        rd("setwins_reg0", 0, 32'h84);
        rd("setwins_reg1", 1, 32'd2);

        // reset mid-pulse, ack still low on release
        sync_flybk = 1'b0;
        tick(4);
        vidc_d = 32'hCAFE0001;
        vidc_nvidak = 1'b0;
        tick(2);
        reset = 1'b1;
        #1;
        chk("mid_rst_load_dma", load_dma, 1'b0);
        chk("mid_rst_data", load_dma_data, 32'h0);
        rd("mid_rst_reg3", 3, 32'h0);
        tick(2);
        reset = 1'b0;
        watch(10, 6, 1'b0);
        chk("post_rst_hits", vhits, 1);
        chk("post_rst_latency", vat, MIN_LOW + 2);
        chk("post_rst_data", vdat, 32'hCAFE0001);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
